// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and dump sequencer state for the register file read path
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} dump_state_t;
endpackage

// File: rtl/reg_pair_buffer.sv
// reg_pair_buffer: two-entry even/odd pair buffer draining one register beat per handshake
module reg_pair_buffer #(
    parameter int N      = 32,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-2:0] ld_pair,
    input  logic [N-1:0]      ld_data0,
    input  logic [N-1:0]      ld_data1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [N-1:0]      out_data,
    output logic              need,
    output logic              last_xfer
);
    logic [1:0]        count;
    logic [ADDR_W-2:0] pair;
    logic [N-1:0]      d0, d1;
    logic              xfer;

    // count==2 means the even entry is at the head, count==1 the odd entry
    always_comb begin
        out_valid = count != 2'd0;
        xfer      = out_valid && out_ready;
        out_addr  = out_valid ? {pair, count == 2'd1} : '0;
        out_data  = !out_valid ? '0 : (count == 2'd1 ? d1 : d0);
        need      = count == 2'd0 || (count == 2'd1 && xfer);
        last_xfer = count == 2'd1 && xfer;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 2'd0;
            pair  <= '0;
            d0    <= '0;
            d1    <= '0;
        end else if (load) begin
            count <= 2'd2;
            pair  <= ld_pair;
            d0    <= ld_data0;
            d1    <= ld_data1;
        end else if (xfer) begin
            count <= count - 2'd1;
        end
    end
endmodule

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: sweeps the register file two registers per fetch and streams (addr, data) beats
module regfile_dump_ctrl #(
    parameter int N        = 32,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [N-1:0]      rd_data0,
    input  logic [N-1:0]      rd_data1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [N-1:0]      out_data
);
    import regfile_pkg::*;

    localparam int PW = ADDR_W - 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_REGS / 2 - 1);

    dump_state_t   state, state_nx;
    logic [PW-1:0] ptr, ptr_nx;
    logic          fetched_all, fa_nx;
    logic          load, need, last_xfer;

    assign rd_addr0 = {ptr, 1'b0};
    assign rd_addr1 = {ptr, 1'b1};

    reg_pair_buffer #(.N(N), .ADDR_W(ADDR_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .ld_pair   (ptr),
        .ld_data0  (rd_data0),
        .ld_data1  (rd_data1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .need      (need),
        .last_xfer (last_xfer)
    );

    // ptr parks on the last pair instead of wrapping; fetched_all blocks further loads
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        fa_nx    = fetched_all;
        busy     = state == RUN;
        done     = state == DONE;
        load     = state == RUN && !fetched_all && need;
        if (state == IDLE && start) begin
            state_nx = RUN;
            ptr_nx   = '0;
            fa_nx    = 1'b0;
        end
        if (load) begin
            fa_nx  = ptr == LAST;
            ptr_nx = ptr == LAST ? ptr : ptr + 1'b1;
        end
        if (state == RUN && fetched_all && last_xfer) state_nx = DONE;
        if (state == DONE) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            fetched_all <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            fetched_all <= fa_nx;
        end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: directed checks of the register file dump sequencer (32- and 8-register builds)
module tb_regfile_dump_ctrl;
    logic        clk = 0, rst = 0, start = 0, out_ready = 0, sel8 = 0;
    logic [31:0] rf [32];
    int          tests = 0, fails = 0, done_cnt = 0;
    logic        ptr8_over = 0;

    logic        busy32, done32, ov32, busy8, done8, ov8;
    logic [4:0]  ra0_32, ra1_32, oa32, ra0_8, ra1_8, oa8;
    logic [31:0] od32, od8;

    logic        busy, done, out_valid;
    logic [4:0]  rd_addr0, rd_addr1, out_addr;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    regfile_dump_ctrl #(.N(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start && !sel8), .busy(busy32), .done(done32),
        .rd_addr0(ra0_32), .rd_addr1(ra1_32),
        .rd_data0(ra0_32 == 5'd0 ? 32'd0 : rf[ra0_32]), .rd_data1(rf[ra1_32]),
        .out_valid(ov32), .out_ready(out_ready), .out_addr(oa32), .out_data(od32)
    );

    regfile_dump_ctrl #(.N(32), .NUM_REGS(8), .ADDR_W(5)) dut8 (
        .clk(clk), .rst(rst), .start(start && sel8), .busy(busy8), .done(done8),
        .rd_addr0(ra0_8), .rd_addr1(ra1_8),
        .rd_data0(ra0_8 == 5'd0 ? 32'd0 : rf[ra0_8]), .rd_data1(rf[ra1_8]),
        .out_valid(ov8), .out_ready(out_ready), .out_addr(oa8), .out_data(od8)
    );

    assign busy      = sel8 ? busy8 : busy32;
    assign done      = sel8 ? done8 : done32;
    assign out_valid = sel8 ? ov8 : ov32;
    assign rd_addr0  = sel8 ? ra0_8 : ra0_32;
    assign rd_addr1  = sel8 ? ra1_8 : ra1_32;
    assign out_addr  = sel8 ? oa8 : oa32;
    assign out_data  = sel8 ? od8 : od32;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (ra0_8 > 5'd6) ptr8_over <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_data(input int i, input bit patched);
        if (i == 0) return 32'd0;
        if (patched && i == 20) return 32'hDEADBEEF;
        return 32'((i + 1) * 17);
    endfunction

    // mode 0: ready=1, 1: ready 1,0,0,1, 2: re-start at beat 10, 3: rf write while stalled at beat 4
    task automatic dump(input int mode, input int nregs);
        int          beats = 0, i = 0, dc;
        bit          held = 0, wrote = 0, restarted = 0;
        logic [4:0]  ha;
        logic [31:0] hd;
        dc = done_cnt;
        out_ready = 1;
        start = 1;
        cyc();
        start = 0;
        check("busy_after_start", busy, 1);
        check("valid_before_load", out_valid, 0);
        while (beats < nregs && i < 400) begin
            out_ready = mode == 1 ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
            start = mode == 2 && beats == 10 && !restarted;
            if (start) restarted = 1;
            if (mode == 3 && beats == 4 && !wrote) begin
                out_ready = 0;
                rf[20] = 32'hDEADBEEF;
                wrote = 1;
            end
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_addr", out_addr, ha);
                check("stall_data", out_data, hd);
            end
            held = out_valid && !out_ready;
            ha = out_addr;
            hd = out_data;
            check("no_early_done", done, 0);
            if (out_valid && out_ready) begin
                check("beat_addr", out_addr, beats[4:0]);
                check("beat_data", out_data, exp_data(beats, wrote));
                beats++;
            end
            cyc();
            i++;
        end
        start = 0;
        check("beat_count", beats, nregs);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", out_valid, 0);
        cyc();
        check("done_one_cycle", done, 0);
        check("done_count", done_cnt - dc, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'((i + 1) * 17);
        rst = 0;
        cyc();
        cyc();
        rst = 1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr0", rd_addr0, 0);
        check("rst_addr1", rd_addr1, 1);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        cyc();
        dump(0, 32);
        dump(1, 32);
        dump(2, 32);

        begin
            int beats = 0, dc;
            dc = done_cnt;
            out_ready = 1;
            start = 1;
            cyc();
            start = 0;
            for (int i = 0; i < 100 && beats < 15; i++) begin
                if (out_valid && out_ready) beats++;
                cyc();
            end
            check("abort_beats", beats, 15);
            rst = 0;
            cyc();
            rst = 1;
            check("abort_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_addr0", rd_addr0, 0);
            check("abort_addr1", rd_addr1, 1);
            check("abort_done", done, 0);
            for (int i = 0; i < 3; i++) cyc();
            check("abort_no_done", done_cnt - dc, 0);
        end
        dump(0, 32);
        dump(3, 32);

        sel8 = 1;
        cyc();
        dump(0, 8);
        check("ptr8_bound", ptr8_over, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
